// File: rtl/freq_bcd_display_if.sv
// Bus between the NCO control registers and the frequency readout:
// operand/start request in one direction, status and display data in the other.
interface freq_bcd_display_if #(
    parameter int FREQ_W  = 18,
    parameter int PHASE_W = 32,
    parameter int DIGITS  = 6
);
    logic [FREQ_W-1:0]   sample_freq;
    logic [PHASE_W-1:0]  phase_inc;
    logic                start;
    logic                busy;
    logic                done;
    logic                valid;
    logic                overflow;
    logic [4*DIGITS-1:0] bcd;
    logic [7*DIGITS-1:0] seg;

    modport master (
        output sample_freq, phase_inc, start,
        input  busy, done, valid, overflow, bcd, seg
    );

    modport slave (
        input  sample_freq, phase_inc, start,
        output busy, done, valid, overflow, bcd, seg
    );
endinterface

// File: rtl/freq_bcd_display.sv
// NCO output-frequency readout: f = (sample_freq * phase_inc) >> PHASE_W, converted to
// BCD by a sequential double-dabble and encoded for active-low seven-segment digits.
module freq_bcd_display #(
    parameter int FREQ_W     = 18,
    parameter int PHASE_W    = 32,
    parameter int DIGITS     = 6,
    parameter int LEAD_BLANK = 1,
    parameter int AUTO       = 0
) (
    input  logic               clk,
    input  logic               reset,
    freq_bcd_display_if.slave  bus
);
    localparam int ND = (FREQ_W + 3) / 3;
    localparam int WW = 4 * ND;
    localparam int PW = FREQ_W + PHASE_W;
    localparam int IW = $clog2(FREQ_W + 1);

    typedef enum logic [1:0] {IDLE, MULT, CONV, LOAD} state_t;
    state_t state_reg, state_next;

    logic [FREQ_W-1:0]   sf_reg;
    logic [PHASE_W-1:0]  pi_reg;
    logic                have_pair_reg;
    logic [FREQ_W-1:0]   bin_reg;
    logic [WW-1:0]       work_reg;
    logic [IW-1:0]       iter_reg;
    logic                busy_reg, done_reg, valid_reg, overflow_reg;
    logic [4*DIGITS-1:0] bcd_reg;
    logic [7*DIGITS-1:0] seg_reg;

    logic [PW-1:0]       product;
    logic [FREQ_W-1:0]   bin_calc;
    logic [WW-1:0]       work_adj;
    logic [4*DIGITS-1:0] bcd_next;
    logic [7*DIGITS-1:0] seg_next;
    logic [DIGITS:0]     upper_zero;
    logic                overflow_next;
    logic                pair_changed, trigger, last_iter;

    // The latched pair doubles as the "last converted" reference for self-start.
    assign pair_changed = !have_pair_reg ||
                          ({bus.sample_freq, bus.phase_inc} != {sf_reg, pi_reg});
    assign trigger      = bus.start || ((AUTO != 0) && pair_changed);
    assign last_iter    = (iter_reg == IW'(FREQ_W - 1));

    assign product  = {{PHASE_W{1'b0}}, sf_reg} * {{FREQ_W{1'b0}}, pi_reg};
    assign bin_calc = FREQ_W'(product >> PHASE_W);

    genvar gi;
    generate
        for (gi = 0; gi < ND; gi++) begin : g_adj
            logic [3:0] d;
            assign d = work_reg[4*gi +: 4];
            assign work_adj[4*gi +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
        end

        if (ND > DIGITS) begin : g_ovf
            assign overflow_next = |work_reg[WW-1:4*DIGITS];
        end else begin : g_no_ovf
            assign overflow_next = 1'b0;
        end

        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] d;
            logic [6:0] code;
            if (gi < ND) begin : g_in
                assign d = work_reg[4*gi +: 4];
            end else begin : g_out
                assign d = 4'd0;
            end
            always_comb begin
                case (d)
                    4'd0:    code = 7'h40;
                    4'd1:    code = 7'h79;
                    4'd2:    code = 7'h24;
                    4'd3:    code = 7'h30;
                    4'd4:    code = 7'h19;
                    4'd5:    code = 7'h12;
                    4'd6:    code = 7'h02;
                    4'd7:    code = 7'h78;
                    4'd8:    code = 7'h00;
                    4'd9:    code = 7'h10;
                    default: code = 7'h7F;
                endcase
            end
            assign bcd_next[4*gi +: 4] = d;
            assign seg_next[7*gi +: 7] = overflow_next ? 7'h3F :
                ((LEAD_BLANK != 0) && (gi > 0) && upper_zero[gi]) ? 7'h7F : code;
        end
    endgenerate

    // upper_zero[i]: digits i..DIGITS-1 are all zero
    always_comb begin
        upper_zero         = '0;
        upper_zero[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (bcd_next[4*i +: 4] == 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (trigger) state_next = MULT;
            MULT:    state_next = CONV;
            CONV:    if (last_iter) state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sf_reg        <= '0;
            pi_reg        <= '0;
            have_pair_reg <= 1'b0;
            bin_reg       <= '0;
            work_reg      <= '0;
            iter_reg      <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            valid_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
            bcd_reg       <= '0;
            seg_reg       <= '1;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: if (trigger) begin
                    sf_reg        <= bus.sample_freq;
                    pi_reg        <= bus.phase_inc;
                    have_pair_reg <= 1'b1;
                    busy_reg      <= 1'b1;
                end
                MULT: begin
                    bin_reg  <= bin_calc;
                    work_reg <= '0;
                    iter_reg <= '0;
                end
                CONV: begin
                    // Top bit of the adjusted register is always 0 after add-3, so it drops out.
                    work_reg <= WW'({work_adj, bin_reg[FREQ_W-1]});
                    bin_reg  <= bin_reg << 1;
                    iter_reg <= iter_reg + IW'(1);
                end
                LOAD: begin
                    bcd_reg      <= bcd_next;
                    seg_reg      <= seg_next;
                    overflow_reg <= overflow_next;
                    valid_reg    <= 1'b1;
                    done_reg     <= 1'b1;
                    busy_reg     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.valid    = valid_reg;
    assign bus.overflow = overflow_reg;
    assign bus.bcd      = bcd_reg;
    assign bus.seg      = seg_reg;
endmodule

// File: tb/tb_freq_bcd_display.sv
// Directed and randomized checks of freq_bcd_display against a decimal-arithmetic model,
// using three instances: defaults, DIGITS=4 without blanking, and AUTO self-start.
module tb_freq_bcd_display;
    localparam int FW = 18;
    localparam int PW = 32;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    freq_bcd_display_if #(.FREQ_W(FW), .PHASE_W(PW), .DIGITS(6)) if0 ();
    freq_bcd_display_if #(.FREQ_W(FW), .PHASE_W(PW), .DIGITS(4)) if1 ();
    freq_bcd_display_if #(.FREQ_W(FW), .PHASE_W(PW), .DIGITS(6)) if2 ();

    freq_bcd_display #(.FREQ_W(FW), .PHASE_W(PW), .DIGITS(6), .LEAD_BLANK(1), .AUTO(0))
        u0 (.clk(clk), .reset(reset), .bus(if0.slave));
    freq_bcd_display #(.FREQ_W(FW), .PHASE_W(PW), .DIGITS(4), .LEAD_BLANK(0), .AUTO(0))
        u1 (.clk(clk), .reset(reset), .bus(if1.slave));
    freq_bcd_display #(.FREQ_W(FW), .PHASE_W(PW), .DIGITS(6), .LEAD_BLANK(1), .AUTO(1))
        u2 (.clk(clk), .reset(reset), .bus(if2.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // sel: 0 bcd, 1 seg, 2 overflow, 3 valid, 4 busy, 5 done
    function automatic logic [63:0] obs(input int which, input int sel);
        logic [63:0] r = '0;
        case (which)
            0: case (sel)
                0: r = 64'(if0.bcd);  1: r = 64'(if0.seg);   2: r = 64'(if0.overflow);
                3: r = 64'(if0.valid); 4: r = 64'(if0.busy); default: r = 64'(if0.done);
            endcase
            1: case (sel)
                0: r = 64'(if1.bcd);  1: r = 64'(if1.seg);   2: r = 64'(if1.overflow);
                3: r = 64'(if1.valid); 4: r = 64'(if1.busy); default: r = 64'(if1.done);
            endcase
            default: case (sel)
                0: r = 64'(if2.bcd);  1: r = 64'(if2.seg);   2: r = 64'(if2.overflow);
                3: r = 64'(if2.valid); 4: r = 64'(if2.busy); default: r = 64'(if2.done);
            endcase
        endcase
        return r;
    endfunction

    function automatic logic [6:0] seg_code(input longint unsigned d);
        logic [6:0] t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return t[d];
    endfunction

    // Reference: exact product, decimal digits by division, blanking by magnitude.
    task automatic check_model(input string tag, input int which,
                               input longint unsigned sf, input longint unsigned pi);
        int                nd = (which == 1) ? 4 : 6;
        bit                lb = (which != 1);
        longint unsigned   f  = (sf * pi) >> PW;
        longint unsigned   p  = 1;
        longint unsigned   d;
        logic [63:0]       eb = '0;
        logic [63:0]       es = '0;
        bit                ovf;
        for (int i = 0; i < nd; i++) begin
            d = (f / p) % 10;
            eb[4*i +: 4] = d[3:0];
            es[7*i +: 7] = (lb && i > 0 && f < p) ? 7'h7F : seg_code(d);
            p = p * 10;
        end
        ovf = (f >= p);
        if (ovf) for (int i = 0; i < nd; i++) es[7*i +: 7] = 7'h3F;
        $display("conv %s u%0d sf=%0d pi=%h f=%0d bcd=%h seg=%h ovf=%0d",
                 tag, which, sf, pi, f, obs(which, 0), obs(which, 1), obs(which, 2));
        chk({tag, "_bcd"},   obs(which, 0), eb);
        chk({tag, "_seg"},   obs(which, 1), es);
        chk({tag, "_ovf"},   obs(which, 2), 64'(ovf));
        chk({tag, "_valid"}, obs(which, 3), 64'd1);
    endtask

    task automatic check_reset(input string tag, input int which);
        int nd = (which == 1) ? 4 : 6;
        chk({tag, "_bcd"},  obs(which, 0), 64'd0);
        chk({tag, "_seg"},  obs(which, 1), (64'd1 << (7 * nd)) - 64'd1);
        chk({tag, "_ovf"},  obs(which, 2), 64'd0);
        chk({tag, "_valid"}, obs(which, 3), 64'd0);
        chk({tag, "_busy"}, obs(which, 4), 64'd0);
        chk({tag, "_done"}, obs(which, 5), 64'd0);
    endtask

    task automatic wait_done(input int which, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (obs(which, 5) == 64'd0 && cyc < 100);
    endtask

    task automatic run_pair(input string tag, input logic [FW-1:0] sf0, input logic [PW-1:0] pi0,
                            input logic [FW-1:0] sf1, input logic [PW-1:0] pi1);
        int cyc;
        if0.sample_freq = sf0; if0.phase_inc = pi0; if0.start = 1'b1;
        if1.sample_freq = sf1; if1.phase_inc = pi1; if1.start = 1'b1;
        tick();
        if0.start = 1'b0;
        if1.start = 1'b0;
        chk({tag, "_busy"}, obs(0, 4), 64'd1);
        wait_done(0, cyc);
        chk({tag, "_latency"}, 64'(cyc), 64'd20);
        chk({tag, "_done_u1"}, obs(1, 5), 64'd1);
        check_model({tag, "_u0"}, 0, 64'(sf0), 64'(pi0));
        check_model({tag, "_u1"}, 1, 64'(sf1), 64'(pi1));
    endtask

    initial begin
        int              n_done;
        int              cyc;
        logic [FW-1:0]   sf2, sa, sb;
        logic [PW-1:0]   pi2, pa, pb;

        reset = 1'b1;
        if0.sample_freq = '0; if0.phase_inc = '0; if0.start = 1'b0;
        if1.sample_freq = '0; if1.phase_inc = '0; if1.start = 1'b0;
        if2.sample_freq = '0; if2.phase_inc = '0; if2.start = 1'b0;
        repeat (3) tick();
        check_reset("rst_u0", 0);
        check_reset("rst_u1", 1);
        reset = 1'b0;
        tick();

        // 5000 kHz * 0.1 = 500; starts during conversion ignored, start in done cycle accepted
        if0.sample_freq = 18'd5000; if0.phase_inc = 32'h1999999A; if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        chk("t1_busy", obs(0, 4), 64'd1);
        n_done = 0;
        sf2 = 18'($urandom_range(1, 262143));
        pi2 = $urandom;
        for (int c = 1; c <= 50; c++) begin
            if0.start = (c == 5 || c == 10 || c == 21);
            if (c == 21) begin
                if0.sample_freq = sf2; if0.phase_inc = pi2;
            end else begin
                if0.sample_freq = 18'($urandom); if0.phase_inc = $urandom;
            end
            tick();
            if (c == 30) begin
                chk("t4_hold_bcd", obs(0, 0), 64'h000500);
                chk("t4_hold_valid", obs(0, 3), 64'd1);
                chk("t4_busy2", obs(0, 4), 64'd1);
            end
            if (obs(0, 5) == 64'd1) begin
                n_done++;
                if (n_done == 1) begin
                    chk("t1_done_cycle", 64'(c), 64'd20);
                    chk("t1_bcd", obs(0, 0), 64'h000500);
                    chk("t1_seg", obs(0, 1), 64'({7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h40, 7'h40}));
                    check_model("t1", 0, 64'd5000, 64'h1999999A);
                end else begin
                    chk("t4_done2_cycle", 64'(c), 64'd41);
                    check_model("t4_second", 0, 64'(sf2), 64'(pi2));
                end
            end
        end
        if0.start = 1'b0;
        chk("t4_done_count", 64'(n_done), 64'd2);

        // zero frequency, blanking vs. no blanking; then overflow on the 4-digit unit
        run_pair("t2", 18'd5000, 32'd0, 18'd5000, 32'd0);
        chk("t2_seg_u0", obs(0, 1), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));
        chk("t2_seg_u1", obs(1, 1), 64'({7'h40, 7'h40, 7'h40, 7'h40}));
        run_pair("t3", 18'd262143, 32'hFFFFFFFF, 18'd262143, 32'hFFFFFFFF);
        chk("t3_bcd_u1", obs(1, 0), 64'h2142);
        chk("t3_seg_u1", obs(1, 1), 64'({7'h3F, 7'h3F, 7'h3F, 7'h3F}));
        chk("t3_ovf_u1", obs(1, 2), 64'd1);

        for (int k = 0; k < 8; k++) begin
            sa = 18'($urandom_range(0, 262143)); pa = $urandom >> $urandom_range(0, 31);
            sb = 18'($urandom_range(0, 262143)); pb = $urandom >> $urandom_range(0, 31);
            run_pair("rnd", sa, pa, sb, pb);
        end

        // reset at edge N+8 aborts the conversion
        if0.sample_freq = 18'd5000; if0.phase_inc = 32'h1999999A; if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset("t5_u0", 0);
        n_done = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (obs(0, 5) == 64'd1) n_done++;
        end
        chk("t5_no_done", 64'(n_done), 64'd0);
        run_pair("t5_fresh", 18'd5000, 32'h1999999A, 18'd1234, 32'h40000000);

        // self-start on input change, silence while inputs stay put
        if2.sample_freq = 18'd1000; if2.phase_inc = 32'h80000000;
        wait_done(2, cyc);
        chk("t6_lat1", 64'(cyc), 64'd21);
        check_model("t6_a", 2, 64'd1000, 64'h80000000);
        chk("t6_bcd1", obs(2, 0), 64'h000500);
        if2.sample_freq = 18'd2000;
        wait_done(2, cyc);
        chk("t6_lat2", 64'(cyc), 64'd21);
        check_model("t6_b", 2, 64'd2000, 64'h80000000);
        chk("t6_bcd2", obs(2, 0), 64'h001000);
        n_done = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (obs(2, 5) == 64'd1) n_done++;
        end
        chk("t6_steady", 64'(n_done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
